// File: rtl/comm_link_pkg.sv
// Shared types and line levels for the host side of the driver-board serial link.
package comm_link_pkg;

    typedef enum logic {TX_IDLE = 1'b0, TX_DATA = 1'b1} tx_state_t;
    typedef enum logic {RX_HUNT = 1'b0, RX_DATA = 1'b1} rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/comm_host_sclk_gen.sv
// Free-running serial clock divider; provides the TX launch tick (falling half) and RX sample tick.
module sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic sclk,
    output logic tick_fall,
    output logic tick_samp
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          sclk_q, sclk_d;

    // sclk rises as the divider wraps and falls at the half count
    always_comb begin
        if (div_cnt_q == LAST) begin
            div_cnt_d = {CW{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
        if (div_cnt_d == {CW{1'b0}}) begin
            sclk_d = 1'b1;
        end else if (div_cnt_d == HALF) begin
            sclk_d = 1'b0;
        end else begin
            sclk_d = sclk_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= {CW{1'b0}};
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk      = sclk_q;
    assign tick_fall = (div_cnt_q == HALF);
    assign tick_samp = (div_cnt_q == LAST);

endmodule

// File: rtl/comm_host.sv
// Host end of the board serial link: sclk generation, TX framing, RX deframing.
// Define COMM_HOST_LOOPBACK_EN to add the loopback port (RX fed from the TX data register).
module comm_host
    import comm_link_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic             tx_rdy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_val,
    input  logic             rx_rd,
    output logic             rx_overrun,
    output logic             busy,
    output logic             sclk,
    output logic             sdata_out,
    input  logic             sdata_in
`ifdef COMM_HOST_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    localparam int BW = $clog2(WIDTH + 1);

    logic tick_fall, tick_samp;

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clock     (clock),
        .reset     (reset),
        .sclk      (sclk),
        .tick_fall (tick_fall),
        .tick_samp (tick_samp)
    );

    tx_state_t        tx_state_q, tx_state_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0]    tx_cnt_q, tx_cnt_d;
    logic             sdata_out_q, sdata_out_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             start_frame;

    // A held word starts on a launch tick when idle or right after the last data bit
    always_comb begin
        start_frame = tick_fall && hold_full_q &&
                      ((tx_state_q == TX_IDLE) || (tx_cnt_q == {BW{1'b0}}));
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        sdata_out_d = sdata_out_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (tx_wr && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        if (start_frame) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
            sdata_out_d = START_BIT;
            tx_cnt_d    = BW'(WIDTH);
            tx_state_d  = TX_DATA;
        end else if (tick_fall) begin
            case (tx_state_q)
                TX_IDLE: begin
                    sdata_out_d = IDLE_LEVEL;
                end
                TX_DATA: begin
                    if (tx_cnt_q != {BW{1'b0}}) begin
                        sdata_out_d = tx_shift_q[WIDTH-1];
                        tx_shift_d  = {tx_shift_q[WIDTH-2:0], 1'b0};
                        tx_cnt_d    = tx_cnt_q - BW'(1);
                    end else begin
                        sdata_out_d = IDLE_LEVEL;
                        tx_state_d  = TX_IDLE;
                    end
                end
                default: begin
                    sdata_out_d = IDLE_LEVEL;
                    tx_state_d  = TX_IDLE;
                end
            endcase
        end else begin
            tx_state_d = tx_state_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= {WIDTH{1'b0}};
            tx_cnt_q    <= {BW{1'b0}};
            sdata_out_q <= IDLE_LEVEL;
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            sdata_out_q <= sdata_out_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    rx_state_t        rx_state_q, rx_state_d;
    logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [BW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_val_q, rx_val_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             sin_q;
    logic             rx_src;
    logic             word_done;
    logic [WIDTH-1:0] rx_word;

`ifdef COMM_HOST_LOOPBACK_EN
    assign rx_src = loopback ? sdata_out_q : sin_q;
`else
    assign rx_src = sin_q;
`endif

    // Only WIDTH-1 bits are stored; the final sample completes the word directly
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_cnt_d     = rx_cnt_q;
        rx_data_d    = rx_data_q;
        rx_val_d     = rx_val_q;
        rx_overrun_d = rx_overrun_q;
        word_done    = tick_samp && (rx_state_q == RX_DATA) && (rx_cnt_q == BW'(1));
        rx_word      = {rx_shift_q, rx_src};

        if (tick_samp) begin
            case (rx_state_q)
                RX_HUNT: begin
                    if (rx_src == START_BIT) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BW'(WIDTH);
                    end else begin
                        rx_state_d = RX_HUNT;
                    end
                end
                RX_DATA: begin
                    rx_shift_d = (WIDTH-1)'(rx_word);
                    rx_cnt_d   = rx_cnt_q - BW'(1);
                    if (rx_cnt_q == BW'(1)) begin
                        rx_state_d = RX_HUNT;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end
                default: begin
                    rx_state_d = RX_HUNT;
                end
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end

        if (word_done) begin
            if (!rx_val_q || rx_rd) begin
                rx_data_d = rx_word;
                rx_val_d  = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_rd && rx_val_q) begin
            rx_val_d = 1'b0;
        end else begin
            rx_val_d = rx_val_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sin_q        <= IDLE_LEVEL;
            rx_state_q   <= RX_HUNT;
            rx_shift_q   <= {(WIDTH-1){1'b0}};
            rx_cnt_q     <= {BW{1'b0}};
            rx_data_q    <= {WIDTH{1'b0}};
            rx_val_q     <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            sin_q        <= sdata_in;
            rx_state_q   <= rx_state_d;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_val_q     <= rx_val_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign tx_rdy     = ~hold_full_q;
    assign busy       = (tx_state_q != TX_IDLE) | hold_full_q;
    assign sdata_out  = sdata_out_q;
    assign rx_data    = rx_data_q;
    assign rx_val     = rx_val_q;
    assign rx_overrun = rx_overrun_q;

endmodule
